// File: rtl/umi_pkg.sv
// -----------------------------------------------------------------------------
// umi_pkg
// Shared definitions for the UMI arbiter: mode encodings, lock FSM states and
// a helper that resolves the mode input to "round-robin or not".
// -----------------------------------------------------------------------------
package umi_pkg;

    // Arbitration mode encodings (2'b10 is reserved and behaves as fixed)
    localparam logic [1:0] UMI_ARB_FIXED = 2'b00;
    localparam logic [1:0] UMI_ARB_RR    = 2'b01;
    localparam logic [1:0] UMI_ARB_RSVD  = 2'b10;
    localparam logic [1:0] UMI_ARB_PARAM = 2'b11;

    // Grant lock states
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } umi_arb_state_e;

    // Resolve the mode input; PARAM defers to the elaboration-time default
    function automatic logic umi_arb_is_rr(input logic [1:0] mode,
                                           input logic       param_rr);
        logic rr;
        rr = 1'b0;
        case (mode)
            UMI_ARB_RR:    rr = 1'b1;
            UMI_ARB_PARAM: rr = param_rr;
            default:       rr = 1'b0;
        endcase
        return rr;
    endfunction

endpackage

// File: rtl/umi_arb_pick.sv
// -----------------------------------------------------------------------------
// umi_arb_pick
// Combinational lowest-index one-hot picker.
// Ports:
//   i_req   [N-1:0]  request vector
//   o_grant [N-1:0]  one-hot of the lowest set bit of i_req (zero if none)
// -----------------------------------------------------------------------------
module umi_arb_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    // x & -x isolates the lowest set bit
    always_comb begin
        o_grant = i_req & (~i_req + N'(1));
    end

endmodule

// File: rtl/umi_arbiter.sv
// -----------------------------------------------------------------------------
// umi_arbiter
// Turns N raw requester valids into a strictly one-hot grant for the UMI
// one-hot mux, returns downstream ready only to the granted requester, and
// locks the grant while the output is stalled.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   mode [1:0]             00 fixed, 01 round-robin, 10 fixed, 11 ROUNDROBIN
//   mask [N-1:0]           1 = requester never newly granted
//   umi_in_valid [N-1:0]   raw requester valids
//   umi_in_ready [N-1:0]   ready back to the granted requester only
//   umi_grant_valid [N-1:0] one-hot (or zero) grant
//   umi_out_valid          OR of the grant
//   umi_out_ready          downstream ready
// -----------------------------------------------------------------------------
module umi_arbiter
    import umi_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter bit          ROUNDROBIN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   mode,
    input  logic [N-1:0] mask,
    input  logic [N-1:0] umi_in_valid,
    output logic [N-1:0] umi_in_ready,
    output logic [N-1:0] umi_grant_valid,
    output logic         umi_out_valid,
    input  logic         umi_out_ready
);

    umi_arb_state_e r_state;
    logic [N-1:0]   r_held;
    logic [N-1:0]   r_rr_mask;

    logic [N-1:0]   w_req;
    logic [N-1:0]   w_req_rr;
    logic [N-1:0]   w_pick_rr;
    logic [N-1:0]   w_pick_all;
    logic [N-1:0]   w_fresh;
    logic [N-1:0]   w_grant;
    logic [N-1:0]   w_rr_next;
    logic           w_rr_mode;
    logic           w_hold_live;
    logic           w_transfer;

    // Eligible requests and the subset still ahead of the round-robin pointer
    always_comb begin
        w_req    = umi_in_valid & ~mask;
        w_req_rr = w_req & r_rr_mask;
    end

    umi_arb_pick #(.N(N)) u_pick_rr (
        .i_req   (w_req_rr),
        .o_grant (w_pick_rr)
    );

    umi_arb_pick #(.N(N)) u_pick_all (
        .i_req   (w_req),
        .o_grant (w_pick_all)
    );

    // Fresh pick: round-robin falls back to the unmasked set when nothing
    // remains above the last winner
    always_comb begin
        w_rr_mode = umi_arb_is_rr(mode, ROUNDROBIN);
        w_fresh   = (w_rr_mode && (|w_req_rr)) ? w_pick_rr : w_pick_all;
    end

    // A hold survives mask and mode changes; it only breaks if the held
    // requester itself drops valid, in which case this cycle re-arbitrates
    always_comb begin
        w_hold_live = (r_state == ARB_HOLD) && (|(r_held & umi_in_valid));
        w_grant     = w_hold_live ? r_held : w_fresh;
    end

    // Outputs are forced low while reset is high, independent of the inputs
    always_comb begin
        umi_grant_valid = reset ? '0 : w_grant;
        umi_out_valid   = |umi_grant_valid;
        umi_in_ready    = umi_grant_valid & {N{umi_out_ready}};
        w_transfer      = umi_out_valid & umi_out_ready;
    end

    // Bits strictly above the one-hot winner; zero when the winner is N-1
    always_comb begin
        w_rr_next = ~(w_grant | (w_grant - N'(1)));
    end

    // Lock FSM and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_held    <= '0;
            r_rr_mask <= '1;
        end else begin
            if (w_transfer && w_rr_mode) begin
                r_rr_mask <= w_rr_next;
            end
            if (r_state == ARB_IDLE) begin
                if ((|w_grant) && !umi_out_ready) begin
                    r_state <= ARB_HOLD;
                    r_held  <= w_grant;
                end
            end else begin
                if (!w_hold_live || umi_out_ready) begin
                    r_state <= ARB_IDLE;
                    r_held  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_umi_arbiter.sv
module tb_umi_arbiter;

    localparam int unsigned N = 4;

    logic         clk;
    logic         reset;
    logic [1:0]   mode;
    logic [N-1:0] mask;
    logic [N-1:0] umi_in_valid;
    logic [N-1:0] umi_in_ready;
    logic [N-1:0] umi_grant_valid;
    logic         umi_out_valid;
    logic         umi_out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state: index of last round-robin winner, lock status
    int m_last;
    bit m_locked;
    int m_held;

    umi_arbiter #(.N(N), .ROUNDROBIN(1'b1)) dut (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .mask            (mask),
        .umi_in_valid    (umi_in_valid),
        .umi_in_ready    (umi_in_ready),
        .umi_grant_valid (umi_grant_valid),
        .umi_out_valid   (umi_out_valid),
        .umi_out_ready   (umi_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_rr(input logic [1:0] md);
        return (md == 2'b01) || (md == 2'b11);
    endfunction

    // Rotating search starting just after the last round-robin winner
    function automatic int model_pick();
        int start;
        int idx;
        start = model_rr(mode) ? (m_last + 1) % N : 0;
        for (int j = 0; j < N; j++) begin
            idx = (start + j) % N;
            if (umi_in_valid[idx] && !mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int model_winner();
        if (m_locked && umi_in_valid[m_held]) return m_held;
        return model_pick();
    endfunction

    function automatic logic [N-1:0] to_vec(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_last   = N - 1;
        m_locked = 1'b0;
        m_held   = 0;
    endtask

    task automatic model_edge(input int g);
        if (g >= 0 && umi_out_ready && model_rr(mode)) m_last = g;
        if (m_locked) begin
            if (!umi_in_valid[m_held] || umi_out_ready) m_locked = 1'b0;
        end else if (g >= 0 && !umi_out_ready) begin
            m_locked = 1'b1;
            m_held   = g;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        umi_in_valid = '0;
        mask = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mode = 2'b01;
        umi_in_valid = 4'b1111;
        umi_out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (umi_grant_valid !== 4'b0000) begin
                errors++;
                $display("FAIL reset_grant got=%b want=0000", umi_grant_valid);
            end
            checks++;
            if (umi_in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_in_ready got=%b want=0000", umi_in_ready);
            end
            checks++;
            if (umi_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid got=%b want=0", umi_out_valid);
            end
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 2'b00;
        umi_in_valid = 4'b1010;
        umi_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) mode = 2'b10;
            #1;
            checks++;
            if (umi_grant_valid !== 4'b0010) begin
                errors++;
                $display("FAIL fixed_grant cyc=%0d got=%b want=0010", c, umi_grant_valid);
            end
            checks++;
            if (umi_in_ready !== 4'b0010) begin
                errors++;
                $display("FAIL fixed_in_ready cyc=%0d got=%b want=0010", c, umi_in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rr_rotate();
        logic [N-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        mode = 2'b01;
        umi_in_valid = 4'b1111;
        umi_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (umi_grant_valid !== seq[c]) begin
                errors++;
                $display("FAIL rr_rotate cyc=%0d got=%b want=%b", c, umi_grant_valid, seq[c]);
            end
            @(negedge clk);
        end
    endtask

    // Hold on requester 1, then release; md selects RR via 01 or via 11
    task automatic test_hold(input logic [1:0] md, input logic [N-1:0] last_valid,
                             input logic [N-1:0] want_next);
        do_reset();
        mode = md;
        umi_in_valid = 4'b0010;
        umi_out_ready = 1'b0;
        #1;
        checks++;
        if (umi_grant_valid !== 4'b0010 || umi_in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL hold_start got=%b/%b want=0010/0000", umi_grant_valid, umi_in_ready);
        end
        @(negedge clk);
        umi_in_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (umi_grant_valid !== 4'b0010 || umi_in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL hold_stall cyc=%0d got=%b/%b want=0010/0000", c, umi_grant_valid, umi_in_ready);
            end
            @(negedge clk);
        end
        umi_out_ready = 1'b1;
        umi_in_valid = last_valid;
        #1;
        checks++;
        if (umi_in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL hold_accept got=%b want=0010", umi_in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (umi_grant_valid !== want_next) begin
            errors++;
            $display("FAIL hold_next got=%b want=%b", umi_grant_valid, want_next);
        end
        @(negedge clk);
    endtask

    task automatic test_mask();
        do_reset();
        mode = 2'b00;
        mask = 4'b0001;
        umi_in_valid = 4'b0011;
        umi_out_ready = 1'b1;
        #1;
        checks++;
        if (umi_grant_valid !== 4'b0010 || umi_in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mask_pick got=%b/%b want=0010/0010", umi_grant_valid, umi_in_ready);
        end
        @(negedge clk);
        umi_out_ready = 1'b0;
        #1;
        checks++;
        if (umi_grant_valid !== 4'b0010) begin
            errors++;
            $display("FAIL mask_stall got=%b want=0010", umi_grant_valid);
        end
        @(negedge clk);
        mask = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (umi_grant_valid !== 4'b0010) begin
                errors++;
                $display("FAIL mask_hold cyc=%0d got=%b want=0010", c, umi_grant_valid);
            end
            @(negedge clk);
        end
        umi_out_ready = 1'b1;
        #1;
        checks++;
        if (umi_in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mask_accept got=%b want=0010", umi_in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (umi_grant_valid !== 4'b0001) begin
            errors++;
            $display("FAIL mask_after got=%b want=0001", umi_grant_valid);
        end
        @(negedge clk);
        mask = '0;
    endtask

    task automatic test_drop();
        do_reset();
        mode = 2'b00;
        umi_in_valid = 4'b0100;
        umi_out_ready = 1'b0;
        @(negedge clk);
        umi_in_valid = 4'b0001;
        #1;
        checks++;
        if (umi_grant_valid !== 4'b0001 || umi_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_refresh got=%b/%b want=0001/1", umi_grant_valid, umi_out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_hold();
        do_reset();
        mode = 2'b01;
        umi_in_valid = 4'b0010;
        umi_out_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (umi_grant_valid !== 4'b0010) begin
            errors++;
            $display("FAIL rsthold_pre got=%b want=0010", umi_grant_valid);
        end
        umi_out_ready = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if (umi_grant_valid !== 4'b0000 || umi_in_ready !== 4'b0000 || umi_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsthold_force got=%b/%b/%b want=0000/0000/0", umi_grant_valid, umi_in_ready, umi_out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        umi_in_valid = 4'b1111;
        #1;
        checks++;
        if (umi_grant_valid !== 4'b0001) begin
            errors++;
            $display("FAIL rsthold_first got=%b want=0001", umi_grant_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] want;
        do_reset();
        model_reset();
        mode = 2'b01;
        for (int c = 0; c < 10000; c++) begin
            umi_in_valid  = N'($urandom);
            mask          = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            umi_out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom);
            #1;
            g = model_winner();
            want = to_vec(g);
            checks++;
            if (umi_grant_valid !== want) begin
                errors++;
                $display("FAIL rand_grant cyc=%0d got=%b want=%b", c, umi_grant_valid, want);
            end
            checks++;
            if (umi_in_ready !== (want & {N{umi_out_ready}})) begin
                errors++;
                $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", c, umi_in_ready, want & {N{umi_out_ready}});
            end
            checks++;
            if (umi_out_valid !== (g >= 0)) begin
                errors++;
                $display("FAIL rand_out_valid cyc=%0d got=%b want=%b", c, umi_out_valid, (g >= 0));
            end
            checks++;
            if ($countones(umi_grant_valid) > 1) begin
                errors++;
                $display("FAIL rand_onehot cyc=%0d got=%b want=popcount<=1", c, umi_grant_valid);
            end
            model_edge(g);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        mode = 2'b00;
        mask = '0;
        umi_in_valid = '0;
        umi_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fixed();
        test_rr_rotate();
        test_hold(2'b01, 4'b0111, 4'b0100);
        test_hold(2'b11, 4'b0011, 4'b0001);
        test_mask();
        test_drop();
        test_reset_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
